// File: rtl/factor_sequencer.sv
// rtl/factor_sequencer.sv - sequential divisibility-by-2..9 engine with ready/start and valid/ack handshakes
module factor_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] number,
    input  logic       start,
    output logic       ready,
    output logic       busy,
    output logic       valid,
    input  logic       ack,
    output logic [7:0] factors
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] num_q, num_d;
    logic [6:0] rem_q, rem_d;
    logic [3:0] div_q, div_d;
    logic [7:0] mask_q, mask_d;

    // Shared compare/subtract unit and the mask bit the current divisor owns
    logic [6:0] div_ext;
    logic       rem_ge_div;
    logic [2:0] bit_idx;

    assign div_ext    = {3'b000, div_q};
    assign rem_ge_div = (rem_q >= div_ext);
    assign bit_idx    = 3'(div_q - 4'd2);

    // State register and datapath registers; reset discards any partial result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            num_q   <= 7'd0;
            rem_q   <= 7'd0;
            div_q   <= 4'd2;
            mask_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            mask_q  <= mask_d;
        end
    end

    // Next-state: accept in IDLE, one subtract-or-record step per cycle in RUN, wait for ack in DONE
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        rem_d   = rem_q;
        div_d   = div_q;
        mask_d  = mask_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d   = number;
                    rem_d   = number;
                    div_d   = 4'd2;
                    mask_d  = 8'd0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (rem_ge_div) begin
                    rem_d = rem_q - div_ext;
                end else begin
                    mask_d[bit_idx] = (rem_q == 7'd0);
                    if (div_q == 4'd9) begin
                        state_d = S_DONE;
                    end else begin
                        div_d = div_q + 4'd1;
                        rem_d = num_q;
                    end
                end
            end
            S_DONE: begin
                if (ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only
    assign ready   = (state_q == S_IDLE);
    assign busy    = (state_q == S_RUN);
    assign valid   = (state_q == S_DONE);
    assign factors = mask_q;

endmodule

// File: tb/tb_factor_sequencer.sv
// tb/tb_factor_sequencer.sv - self-checking bench for factor_sequencer against an arithmetic model
module tb_factor_sequencer;

    logic       clk;
    logic       rst_n;
    logic [6:0] number;
    logic       start;
    logic       ready;
    logic       busy;
    logic       valid;
    logic       ack;
    logic [7:0] factors;

    int checks;
    int errors;

    factor_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .number  (number),
        .start   (start),
        .ready   (ready),
        .busy    (busy),
        .valid   (valid),
        .ack     (ack),
        .factors (factors)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_mask(input int n);
        int m;
        m = 0;
        for (int k = 0; k < 8; k++) begin
            if ((n % (k + 2)) == 0) m |= (1 << k);
        end
        return m;
    endfunction

    function automatic int exp_steps(input int n);
        int s;
        s = 0;
        for (int d = 2; d <= 9; d++) s += (n / d) + 1;
        return s;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_accept(input int n);
        number = 7'(n);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        check("accept_busy", int'(busy), 1);
        check("accept_ready", int'(ready), 0);
    endtask

    // Counts edges after the accepting edge until valid; optional noise on start/number while running
    task automatic wait_result(input int n, input bit noise);
        int k;
        k = 0;
        while (!valid && k < 300) begin
            if (noise) begin
                start  = 1'($urandom);
                number = 7'($urandom);
            end
            @(posedge clk);
            #1;
            k++;
        end
        start = 1'b0;
        check("latency", k, exp_steps(n));
        check("factors", int'(factors), exp_mask(n));
    endtask

    task automatic do_ack(input int n, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", int'(valid), 1);
            check("hold_factors", int'(factors), exp_mask(n));
        end
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        check("ack_ready", int'(ready), 1);
        check("ack_valid", int'(valid), 0);
        check("ack_keep", int'(factors), exp_mask(n));
    endtask

    task automatic run_one(input int n, input int hold, input bit noise);
        do_accept(n);
        wait_result(n, noise);
        do_ack(n, hold);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        number = 7'd0;
        start  = 1'b0;
        ack    = 1'b0;
        #12;
        check("rst_ready", int'(ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_factors", int'(factors), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a long run
        do_accept(127);
        repeat (50) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrun_ready", int'(ready), 1);
        check("midrun_busy", int'(busy), 0);
        check("midrun_valid", int'(valid), 0);
        check("midrun_factors", int'(factors), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed results, ack on the first valid cycle
        run_one(12, 0, 1'b0);
        check("n12_model", exp_mask(12) + (exp_steps(12) << 8), 'h17 + (28 << 8));
        run_one(35, 0, 1'b0);
        run_one(72, 0, 1'b0);
        run_one(1, 0, 1'b0);
        run_one(0, 0, 1'b0);
        run_one(127, 0, 1'b0);

        // Long ack hold, then start noise during RUN
        run_one(60, 20, 1'b0);
        run_one(72, 0, 1'b1);

        // ack and start together in DONE: ack wins, start accepted one edge later
        do_accept(50);
        wait_result(50, 1'b0);
        ack    = 1'b1;
        start  = 1'b1;
        number = 7'd9;
        @(posedge clk);
        #1;
        ack = 1'b0;
        check("simul_ready", int'(ready), 1);
        check("simul_busy", int'(busy), 0);
        check("simul_valid", int'(valid), 0);
        @(posedge clk);
        #1;
        start  = 1'b0;
        number = 7'd100;
        check("simul_accept", int'(busy), 1);
        wait_result(9, 1'b0);
        check("simul_result", int'(factors), 'h82);
        do_ack(9, 0);

        // Full sweep with random ack delays
        for (int n = 0; n < 128; n++) begin
            run_one(n, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
